// File: rtl/bcd_xs3_pkg.sv
// Shared definitions for the BCD -> excess-3 sequential converter.
// Imported by the converter RTL and by its testbench.
package bcd_xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/xs3_digit.sv
// Single-digit BCD -> excess-3 converter (purely combinational).
// Ports:
//   digit   - 4-bit BCD digit in
//   xs3     - (digit + 3) mod 16; no carry out
//   invalid - digit is not a legal BCD value (> 9)
import bcd_xs3_pkg::*;

module xs3_digit (
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] xs3,
    output logic               invalid
);

    // 4-bit add wraps naturally, so 1101 -> 0000 without spilling into
    // the neighbouring digit.
    assign xs3     = digit + XS3_OFFSET;
    assign invalid = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_xs3_seq.sv
// Sequential BCD -> excess-3 word converter. One digit per cycle through
// a single shared xs3_digit instance, least-significant digit first.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - input handshake; in_ready high only in IDLE
//   bcd_in              - packed BCD word, digit 0 in [3:0]
//   out_valid, out_ready- output handshake; out_valid high only in DONE
//   xs3_out             - excess-3 result, same packing as bcd_in
//   err                 - some input digit was > 9
//   busy                - state is not IDLE
import bcd_xs3_pkg::*;

module bcd_xs3_seq #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGITS*DIGIT_W-1:0] bcd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGITS*DIGIT_W-1:0] xs3_out,
    output logic                      err,
    output logic                      busy
);

    localparam int              IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q;
    logic [DIGITS*DIGIT_W-1:0]   word_q;
    logic [DIGITS*DIGIT_W-1:0]   result_q;
    logic                        err_q;

    logic [DIGIT_W-1:0]          cur_digit;
    logic [DIGIT_W-1:0]          cur_xs3;
    logic                        cur_invalid;
    logic                        accept;
    logic                        release_done;

    assign accept       = in_valid  && (state_q == IDLE);
    assign release_done = out_ready && (state_q == DONE);

    assign cur_digit = word_q[idx_q*DIGIT_W +: DIGIT_W];

    xs3_digit u_digit (
        .digit   (cur_digit),
        .xs3     (cur_xs3),
        .invalid (cur_invalid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)         state_d = CONV;
            CONV:    if (idx_q == LAST)  state_d = DONE;
            DONE:    if (release_done)   state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Datapath: word latch, per-digit result write and error accumulation.
    // The result register is not cleared on accept; every nibble is
    // rewritten before out_valid rises again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            word_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            word_q <= bcd_in;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else if (state_q == CONV) begin
            result_q[idx_q*DIGIT_W +: DIGIT_W] <= cur_xs3;
            err_q <= err_q | cur_invalid;
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign xs3_out   = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Directed self-checking bench for bcd_xs3_seq (DIGITS = 4).
import bcd_xs3_pkg::*;

module tb_bcd_xs3_seq;

    localparam int DIGITS = 4;
    localparam int W      = DIGITS * DIGIT_W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] bcd_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] xs3_out;
    logic         err;
    logic         busy;

    int errors = 0;
    int checks = 0;

    bcd_xs3_seq #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xs3_out   (xs3_out),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (xs3_out !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: xs3_out=%h err=%b, want 0000 0", xs3_out, err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Accept one word, wait for out_valid, check latency and result.
    // Leaves the block in DONE (no output handshake yet).
    task automatic run_word(input logic [W-1:0] word, input logic [W-1:0] exp,
                            input logic exp_err, input string name);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        bcd_in   = word;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: busy=%b in_ready=%b, want 1 0", name, busy, in_ready);
        end
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc !== DIGITS) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, cyc, DIGITS);
        end
        checks++;
        if (xs3_out !== exp || err !== exp_err) begin
            errors++;
            $display("FAIL %s_result: xs3_out=%h err=%b, want %h %b",
                     name, xs3_out, err, exp, exp_err);
        end
    endtask

    task automatic handshake_out(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_convert();
        run_word(16'h1234, 16'h4567, 1'b0, "w1234");
        handshake_out("w1234");
        checks++;
        if (xs3_out !== 16'h4567 || err !== 1'b0) begin
            errors++;
            $display("FAIL w1234_hold: xs3_out=%h err=%b, want 4567 0", xs3_out, err);
        end
        run_word(16'h0999, 16'h3CCC, 1'b0, "w0999");
        handshake_out("w0999");
        run_word(16'h9D05, 16'hC038, 1'b1, "w9D05");
        handshake_out("w9D05");
    endtask

    task automatic test_stall();
        run_word(16'h1234, 16'h4567, 1'b0, "stall");
        in_valid = 1'b1;
        bcd_in   = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                xs3_out !== 16'h4567 || err !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b xs3_out=%h err=%b, want 1 0 4567 0",
                         i, out_valid, in_ready, xs3_out, err);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || xs3_out !== 16'h4567 || err !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b xs3_out=%h err=%b, want 1 4567 0",
                     in_ready, xs3_out, err);
        end
    endtask

    task automatic test_reset_mid();
        bcd_in   = 16'h5678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            xs3_out !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b xs3_out=%h err=%b, want 1 0 0 0000 0",
                     in_ready, out_valid, busy, xs3_out, err);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_word(16'h0000, 16'h3333, 1'b0, "after_rst");
        handshake_out("after_rst");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_w[2];
        int           acc_cyc[2];
        int           n_acc, n_res, cyc;
        logic         acc, res;
        logic [W-1:0] seen;
        logic         seen_err;
        exp_w[0] = 16'h3456;
        exp_w[1] = 16'h789A;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        n_acc = 0; n_res = 0; cyc = 0;
        bcd_in    = 16'h0123;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (n_res < 2 && cyc < 40) begin
            acc      = in_ready & in_valid;
            res      = out_valid;
            seen     = xs3_out;
            seen_err = err;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                bcd_in = 16'h4567;
                if (n_acc == 2) in_valid = 1'b0;
            end
            if (res) begin
                checks++;
                if (seen !== exp_w[n_res] || seen_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: xs3_out=%h err=%b, want %h 0",
                             n_res, seen, seen_err, exp_w[n_res]);
                end
                n_res++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (n_res !== 2 || n_acc !== 2) begin
            errors++;
            $display("FAIL b2b_count: results=%0d accepts=%0d, want 2 2", n_res, n_acc);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== DIGITS + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, want %0d",
                     acc_cyc[1] - acc_cyc[0], DIGITS + 2);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
